fb_scanout: RTL
===============

// Module: fb_scanout
// PURPOSE
//  Frame-buffer reader: the display end of the 320x240x8b frame buffer the rasterizer writes.
//  Generates 640x480@60 VGA timing on the pixel clock and fetches each FB pixel twice per line
//  and on two lines (2x2 doubling). Expands RGB332 to 4:4:4 RGB for the video encoder.
//  Provides frame_start/vblank so the render pipeline can sync triangle submission to vblank.
// PARAMETERS
//  H_VIS    640  visible pixels per line
//  H_FP     16   horizontal front porch
//  H_SYNC   96   hsync width
//  H_BP     48   horizontal back porch
//  V_VIS    480  visible lines
//  V_FP     10   vertical front porch
//  V_SYNC   2    vsync width
//  V_BP     33   vertical back porch
//  FB_W     320  frame-buffer width (H_VIS/2)
//  FB_PIX   76800  pixels per buffer (FB_W*V_VIS/2)
//  RD_LAT   2    FB read latency, cycles from fb_addr/fb_rd_en to fb_rdata
// PORTS
//  clk         in   1   25 MHz pixel clock
//  rst         in   1   synchronous, active-high reset
//  fb_rd_en    out  1   FB read strobe, high only in visible region
//  fb_addr     out  18  FB read address
//  fb_rdata    in   8   FB read data, RGB332 {R[2:0],G[2:0],B[1:0]}
//  swap_req    in   1   one-cycle pulse: render done, swap buffers (DOUBLE_BUFFER_EN only)
//  swap_ack    out  1   one-cycle pulse: swap performed
//  hsync       out  1   active-low horizontal sync
//  vsync       out  1   active-low vertical sync
//  active      out  1   visible pixel on red/green/blue
//  red/green/blue out 4 each  pixel colour, 0 when !active
//  frame_start out  1   one-cycle pulse, hc=0 vc=0 (pre-pipeline)
//  vblank      out  1   high while vc >= V_VIS (pre-pipeline)
// BEHAVIOUR
//  Reset: hc=vc=0, all outputs 0 except hsync=vsync=1; pipeline registers cleared; front buffer 0.
//  Counters: hc 0..H_TOT-1 (800), vc 0..V_TOT-1 (525); vc steps when hc wraps; both wrap to 0.
//  Visible: hc<H_VIS && vc<V_VIS. Sync low for hc in [656,751], vc in [490,491].
//  Address: incremental, no multiplier. addr=line_base+pix, pix increments on odd hc in visible.
//   End of visible line (hc=639): pix<=0; if vc odd line_base+=FB_W else line_base kept.
//   vc=479 end: line_base<=0. Last address per frame = 76799.
//  fb_rd_en/fb_addr are combinational from counters and registers (stage 0).
//  hsync/vsync/active delayed RD_LAT cycles through a shift register to align with fb_rdata.
//  Output stage registered: counter position to pins = RD_LAT+1 cycles (3 by default).
//  Colour: R={r2,r1,r0,r2}, G={g2,g1,g0,g2}, B={b1,b0,b1,b0}; forced 0 when delayed active=0.
//  fb_rdata outside the aligned visible slot is ignored.
//  frame_start/vblank are NOT delayed; consumers tolerate the 3-cycle skew.
//  Reset mid-frame: next cycle restarts at hc=vc=0, line_base=0; any pending swap dropped.
// CONFIGURATION
//  DOUBLE_BUFFER_EN defined:
//   Base address = 0 (front=0) or FB_PIX (front=1); fb_addr max 153599.
//   swap_req sets swap_pending (held until serviced; repeated requests merge).
//   At hc=0, vc=V_VIS (start of vblank) with swap_pending: toggle front, clear pending,
//   pulse swap_ack same cycle. swap_req on that exact cycle is serviced immediately.
//  Not defined: base always 0, fb_addr[17]=0, swap_req ignored, swap_ack tied 0.
// TESTING
//  Reset 5 cycles -> hsync=vsync=1, active=0, rgb=0, fb_rd_en=0, frame_start=0.
//  Line 0: fb_addr sequence 0,0,1,1,...,319,319 at hc 0..639; line 1 repeats 0..319; line 2 starts 320.
//  Frame end: addr at vc=479 hc=639 is 76799; addr at next vc=0 hc=0 is 0; frame_start pulse once per 420000 cycles.
//  Sync: hsync low exactly 96 cycles from hc=656+3 pipeline; vsync low 2 lines (1600 cycles).
//  Colour: fb_rdata=8'hE0 -> R=F,G=0,B=0; 8'h1C -> G=F; 8'h03 -> B=F; 8'h92 -> R=9,G=9,B=A, 3 cycles later.
//  DOUBLE_BUFFER_EN: swap_req at vc=100 -> swap_ack at vc=480 hc=0; next frame line 0 addr starts 76800.

Source files
------------

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: frame-buffer read port between the scanout (master) and the FB memory (slave).
// The slave returns rdata a fixed number of cycles after addr/rd_en are presented.
interface fb_scanout_if;
    logic        rd_en;
    logic [17:0] addr;
    logic [7:0]  rdata;

    modport master (output rd_en, output addr, input rdata);
    modport slave  (input rd_en, input addr, output rdata);
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: VGA scanout of an RGB332 frame buffer with 2x2 pixel doubling and 4:4:4 output.
// Define DOUBLE_BUFFER_EN to add front/back buffer swapping synchronised to the start of vblank.
module fb_scanout #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned FB_W   = H_VIS / 2,
    parameter int unsigned FB_PIX = FB_W * V_VIS / 2,
    parameter int unsigned RD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    fb_scanout_if.master fb,
    input  logic         swap_req_i,
    output logic         swap_ack_o,
    output logic         hsync_o,
    output logic         vsync_o,
    output logic         active_o,
    output logic [3:0]   red_o,
    output logic [3:0]   green_o,
    output logic [3:0]   blue_o,
    output logic         frame_start_o,
    output logic         vblank_o
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    localparam int unsigned PW    = $clog2(FB_W);
    localparam int unsigned AW    = 18;

    logic [HW-1:0]     hc_q, hc_d;
    logic [VW-1:0]     vc_q, vc_d;
    logic [PW-1:0]     pix_q, pix_d;
    logic [AW-1:0]     line_base_q, line_base_d;
    logic [AW-1:0]     base;
    logic              visible, hs_n, vs_n;
    logic [RD_LAT-1:0] act_pipe_q, hs_pipe_q, vs_pipe_q;
    logic              hsync_q, vsync_q, active_q;
    logic [3:0]        red_q, green_q, blue_q;

    assign visible = (hc_q < HW'(H_VIS)) && (vc_q < VW'(V_VIS));
    assign hs_n    = !((hc_q >= HW'(H_VIS + H_FP)) && (hc_q < HW'(H_VIS + H_FP + H_SYNC)));
    assign vs_n    = !((vc_q >= VW'(V_VIS + V_FP)) && (vc_q < VW'(V_VIS + V_FP + V_SYNC)));

    // Stage 0: the read request comes straight off the counters.
    assign fb.rd_en = visible && !rst;
    assign fb.addr  = base + line_base_q + AW'(pix_q);

    assign frame_start_o = !rst && (hc_q == '0) && (vc_q == '0);
    assign vblank_o      = !rst && (vc_q >= VW'(V_VIS));

    // Each FB pixel covers two columns and two lines, so pix steps on odd columns and
    // line_base only advances after odd lines.
    always_comb begin
        hc_d        = hc_q + HW'(1);
        vc_d        = vc_q;
        pix_d       = pix_q;
        line_base_d = line_base_q;
        if (hc_q == HW'(H_TOT - 1)) begin
            hc_d = '0;
            vc_d = (vc_q == VW'(V_TOT - 1)) ? '0 : vc_q + VW'(1);
        end
        if (visible) begin
            if (hc_q == HW'(H_VIS - 1)) begin
                pix_d = '0;
                if (vc_q == VW'(V_VIS - 1)) begin
                    line_base_d = '0;
                end else if (vc_q[0]) begin
                    line_base_d = line_base_q + AW'(FB_W);
                end
            end else if (hc_q[0]) begin
                pix_d = pix_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q        <= '0;
            vc_q        <= '0;
            pix_q       <= '0;
            line_base_q <= '0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            pix_q       <= pix_d;
            line_base_q <= line_base_d;
        end
    end

    // Timing strobes ride a RD_LAT-deep delay line so they meet fb.rdata at the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            active_q   <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
        end else begin
            act_pipe_q <= RD_LAT'({act_pipe_q, visible});
            hs_pipe_q  <= RD_LAT'({hs_pipe_q, hs_n});
            vs_pipe_q  <= RD_LAT'({vs_pipe_q, vs_n});
            hsync_q    <= hs_pipe_q[RD_LAT-1];
            vsync_q    <= vs_pipe_q[RD_LAT-1];
            active_q   <= act_pipe_q[RD_LAT-1];
            if (act_pipe_q[RD_LAT-1]) begin
                red_q   <= {fb.rdata[7:5], fb.rdata[7]};
                green_q <= {fb.rdata[4:2], fb.rdata[4]};
                blue_q  <= {fb.rdata[1:0], fb.rdata[1:0]};
            end else begin
                red_q   <= '0;
                green_q <= '0;
                blue_q  <= '0;
            end
        end
    end

    assign hsync_o  = hsync_q;
    assign vsync_o  = vsync_q;
    assign active_o = active_q;
    assign red_o    = red_q;
    assign green_o  = green_q;
    assign blue_o   = blue_q;

`ifdef DOUBLE_BUFFER_EN
    logic front_q, pending_q, swap_now;

    // A request landing on the service cycle itself is taken without passing through pending.
    assign swap_now   = (hc_q == '0) && (vc_q == VW'(V_VIS)) && (pending_q || swap_req_i);
    assign swap_ack_o = swap_now && !rst;
    assign base       = front_q ? AW'(FB_PIX) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            front_q   <= 1'b0;
            pending_q <= 1'b0;
        end else if (swap_now) begin
            front_q   <= ~front_q;
            pending_q <= 1'b0;
        end else if (swap_req_i) begin
            pending_q <= 1'b1;
        end
    end
`else
    logic unused_swap;

    assign unused_swap = swap_req_i | (FB_PIX == 0);
    assign swap_ack_o  = 1'b0;
    assign base        = '0;
`endif

endmodule
